// File: rtl/writeback_commit_if.sv
// Retire-stage bundle: upstream instruction lanes, GPR write port, CSR write
// port and commit reporting, grouped for the writeback/commit stage.
interface writeback_commit_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 64
);
    logic [LANES-1:0]      in_valid;
    logic                  in_ready;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES*XLEN-1:0] in_result;
    logic [LANES*5-1:0]    in_dst;
    logic [LANES-1:0]      in_regwrite;
    logic [LANES-1:0]      in_csr_we;
    logic [LANES*12-1:0]   in_csr_addr;
    logic [LANES*XLEN-1:0] in_csr_data;

    logic [LANES-1:0]      rf_we;
    logic [LANES*5-1:0]    rf_waddr;
    logic [LANES*XLEN-1:0] rf_wdata;

    logic                  csr_write_valid;
    logic [11:0]           csr_write_addr;
    logic [XLEN-1:0]       csr_write_data;
    logic                  csr_write_ready;
    logic                  csr_pending;

    logic [LANES-1:0]      commit_valid;
    logic [LANES*XLEN-1:0] commit_pc;
    logic [63:0]           instret;

    modport slave (
        input  in_valid, in_pc, in_result, in_dst, in_regwrite,
               in_csr_we, in_csr_addr, in_csr_data, csr_write_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata,
               csr_write_valid, csr_write_addr, csr_write_data, csr_pending,
               commit_valid, commit_pc, instret
    );

    modport master (
        output in_valid, in_pc, in_result, in_dst, in_regwrite,
               in_csr_we, in_csr_addr, in_csr_data, csr_write_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata,
               csr_write_valid, csr_write_addr, csr_write_data, csr_pending,
               commit_valid, commit_pc, instret
    );
endinterface

// File: rtl/writeback_commit.sv
// Multi-lane writeback/commit stage: registered GPR writes with same-bundle
// WAW squash, commit/instret reporting, and an in-order CSR write buffer.
module writeback_commit #(
    parameter int LANES     = 2,
    parameter int XLEN      = 64,
    parameter int CSR_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    writeback_commit_if.slave bus
);
    localparam int CW = $clog2(CSR_DEPTH + 1);
    localparam int PW = (CSR_DEPTH > 1) ? $clog2(CSR_DEPTH) : 1;

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [11:0]           csr_addr_q [CSR_DEPTH];
    logic [XLEN-1:0]       csr_data_q [CSR_DEPTH];
    logic [LANES-1:0]      accept;
    logic [LANES-1:0]      enq_en;
    logic [PW-1:0]         enq_idx [LANES];
    logic [CW-1:0]         n_enq;
    logic                  deq;
    logic [LANES-1:0]      rf_we_d, rf_we_q;
    logic [LANES*5-1:0]    rf_waddr_q;
    logic [LANES*XLEN-1:0] rf_wdata_q;
    logic [LANES-1:0]      commit_valid_q;
    logic [LANES*XLEN-1:0] commit_pc_q;
    logic [63:0]           instret_q, instret_d;

    // Conservative: only room for a full bundle counts, ignoring any same-cycle drain.
    assign bus.in_ready = (count_q <= CW'(CSR_DEPTH - LANES));

    always_comb begin
        accept    = bus.in_valid & {LANES{bus.in_ready}};
        rf_we_d   = '0;
        enq_en    = '0;
        n_enq     = '0;
        instret_d = instret_q;
        for (int i = 0; i < LANES; i++) begin
            enq_idx[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            rf_we_d[i] = accept[i] & bus.in_regwrite[i] & (bus.in_dst[i*5 +: 5] != 5'd0);
            // A younger lane hitting the same register supersedes this one.
            for (int j = i + 1; j < LANES; j++) begin
                if (accept[j] && bus.in_regwrite[j] &&
                    bus.in_dst[j*5 +: 5] == bus.in_dst[i*5 +: 5]) begin
                    rf_we_d[i] = 1'b0;
                end
            end
            if (accept[i] && bus.in_csr_we[i]) begin
                enq_en[i]  = 1'b1;
                enq_idx[i] = PW'((int'(tail_q) + int'(n_enq)) % CSR_DEPTH);
                n_enq      = n_enq + CW'(1);
            end
            instret_d = instret_d + 64'(accept[i]);
        end
        deq     = (count_q != '0) & bus.csr_write_ready;
        count_d = count_q + n_enq - CW'(deq);
        tail_d  = PW'((int'(tail_q) + int'(n_enq)) % CSR_DEPTH);
        head_d  = PW'((int'(head_q) + int'(deq)) % CSR_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            rf_we_q        <= '0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= '0;
            commit_pc_q    <= '0;
            instret_q      <= '0;
            for (int k = 0; k < CSR_DEPTH; k++) begin
                csr_addr_q[k] <= '0;
                csr_data_q[k] <= '0;
            end
        end else begin
            count_q        <= count_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= bus.in_dst;
            rf_wdata_q     <= bus.in_result;
            commit_valid_q <= accept;
            commit_pc_q    <= bus.in_pc;
            instret_q      <= instret_d;
            for (int i = 0; i < LANES; i++) begin
                if (enq_en[i]) begin
                    csr_addr_q[enq_idx[i]] <= bus.in_csr_addr[i*12 +: 12];
                    csr_data_q[enq_idx[i]] <= bus.in_csr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    assign bus.rf_we           = rf_we_q;
    assign bus.rf_waddr        = rf_waddr_q;
    assign bus.rf_wdata        = rf_wdata_q;
    assign bus.commit_valid    = commit_valid_q;
    assign bus.commit_pc       = commit_pc_q;
    assign bus.instret         = instret_q;
    assign bus.csr_write_valid = (count_q != '0);
    assign bus.csr_pending     = (count_q != '0);
    assign bus.csr_write_addr  = csr_addr_q[head_q];
    assign bus.csr_write_data  = csr_data_q[head_q];
endmodule

// File: tb/tb_writeback_commit.sv
// Scoreboard bench for writeback_commit: stimulus pushes expected commits and
// CSR writes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_writeback_commit;
    typedef struct {
        logic [1:0]   cv;
        logic [1:0]   we;
        logic [127:0] pc;
        logic [9:0]   waddr;
        logic [127:0] wdata;
        logic [63:0]  instret;
    } commit_t;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
    } csr_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_instret = 64'd0;
    commit_t cq[$];
    csr_t    sq[$];

    writeback_commit_if #(.LANES(2), .XLEN(64)) bus ();

    writeback_commit #(.LANES(2), .XLEN(64), .CSR_DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid    = '0;
        bus.in_pc       = '0;
        bus.in_result   = '0;
        bus.in_dst      = '0;
        bus.in_regwrite = '0;
        bus.in_csr_we   = '0;
        bus.in_csr_addr = '0;
        bus.in_csr_data = '0;
    endtask

    task automatic lane(input int i, input logic [63:0] pc, input logic rw, input logic [4:0] dst,
                        input logic [63:0] res, input logic cw, input logic [11:0] ca,
                        input logic [63:0] cd);
        bus.in_valid[i]           = 1'b1;
        bus.in_pc[i*64 +: 64]     = pc;
        bus.in_regwrite[i]        = rw;
        bus.in_dst[i*5 +: 5]      = dst;
        bus.in_result[i*64 +: 64] = res;
        bus.in_csr_we[i]          = cw;
        bus.in_csr_addr[i*12 +: 12] = ca;
        bus.in_csr_data[i*64 +: 64] = cd;
    endtask

    // Expected commit for the bundle currently driven, assumed accepted.
    task automatic push_commit(input logic [1:0] we);
        commit_t e;
        e.cv    = bus.in_valid;
        e.we    = we;
        e.pc    = bus.in_pc;
        e.waddr = bus.in_dst;
        e.wdata = bus.in_result;
        exp_instret = exp_instret + 64'(bus.in_valid[0]) + 64'(bus.in_valid[1]);
        e.instret = exp_instret;
        cq.push_back(e);
    endtask

    task automatic push_csr(input logic [11:0] a, input logic [63:0] d);
        csr_t e;
        e.addr = a;
        e.data = d;
        sq.push_back(e);
    endtask

    // Monitor
    initial begin
        commit_t c;
        csr_t    s;
        forever begin
            @(negedge clk);
            if (bus.commit_valid != 2'b00) begin
                if (cq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got commit_valid=%b expected none", bus.commit_valid);
                end else begin
                    c = cq.pop_front();
                    chk("commit_valid", bus.commit_valid, c.cv);
                    chk("rf_we", bus.rf_we, c.we);
                    chk("commit_pc", bus.commit_pc, c.pc);
                    chk("instret", bus.instret, c.instret);
                    for (int i = 0; i < 2; i++) begin
                        if (c.we[i]) begin
                            chk("rf_waddr", bus.rf_waddr[i*5 +: 5], c.waddr[i*5 +: 5]);
                            chk("rf_wdata", bus.rf_wdata[i*64 +: 64], c.wdata[i*64 +: 64]);
                        end
                    end
                end
            end
            if (bus.csr_write_valid && bus.csr_write_ready) begin
                if (sq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL csr_unexpected: got addr=%0h expected none", bus.csr_write_addr);
                end else begin
                    s = sq.pop_front();
                    chk("csr_write_addr", bus.csr_write_addr, s.addr);
                    chk("csr_write_data", bus.csr_write_data, s.data);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        reset = 1'b1;
        bus.csr_write_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_we", bus.rf_we, 2'b00);
        chk("rst_commit_valid", bus.commit_valid, 2'b00);
        chk("rst_csr_valid", bus.csr_write_valid, 1'b0);
        chk("rst_csr_pending", bus.csr_pending, 1'b0);
        chk("rst_instret", bus.instret, 64'd0);
        chk("rst_csr_head", {bus.csr_write_addr, bus.csr_write_data}, '0);
        chk("rst_regs", {bus.rf_waddr, bus.rf_wdata, bus.commit_pc}, '0);

        // Basic two-lane bundle
        step();
        reset = 1'b0;
        lane(0, 64'h8000_0000, 1'b1, 5'd5, 64'h11, 1'b0, 12'h0, 64'h0);
        lane(1, 64'h8000_0004, 1'b1, 5'd6, 64'h22, 1'b0, 12'h0, 64'h0);
        push_commit(2'b11);
        @(negedge clk);
        chk("ready_after_reset", bus.in_ready, 1'b1);

        // Same-bundle WAW: youngest lane wins
        step();
        idle();
        lane(0, 64'h8000_0008, 1'b1, 5'd7, 64'h1, 1'b0, 12'h0, 64'h0);
        lane(1, 64'h8000_000c, 1'b1, 5'd7, 64'h2, 1'b0, 12'h0, 64'h0);
        push_commit(2'b10);

        // x0 destination never writes, still retires
        step();
        idle();
        lane(0, 64'h8000_0010, 1'b1, 5'd0, 64'h33, 1'b0, 12'h0, 64'h0);
        lane(1, 64'h8000_0014, 1'b0, 5'd3, 64'h44, 1'b0, 12'h0, 64'h0);
        push_commit(2'b00);

        // Two CSR writes in one bundle drain in order on consecutive cycles
        step();
        idle();
        bus.csr_write_ready = 1'b1;
        lane(0, 64'h8000_0018, 1'b0, 5'd0, 64'h0, 1'b1, 12'h300, 64'hA);
        lane(1, 64'h8000_001c, 1'b0, 5'd0, 64'h0, 1'b1, 12'h305, 64'hB);
        push_commit(2'b00);
        push_csr(12'h300, 64'hA);
        push_csr(12'h305, 64'hB);
        step();
        idle();
        @(negedge clk);
        chk("csr_head_first", bus.csr_write_addr, 12'h300);
        step();
        step();
        @(negedge clk);
        chk("csr_drained", bus.csr_pending, 1'b0);

        // Fill the buffer with ready low, then stall
        step();
        bus.csr_write_ready = 1'b0;
        lane(0, 64'h8000_0020, 1'b0, 5'd0, 64'h0, 1'b1, 12'h340, 64'h1);
        lane(1, 64'h8000_0024, 1'b0, 5'd0, 64'h0, 1'b1, 12'h341, 64'h2);
        push_commit(2'b00);
        push_csr(12'h340, 64'h1);
        push_csr(12'h341, 64'h2);
        step();
        idle();
        lane(0, 64'h8000_0028, 1'b0, 5'd0, 64'h0, 1'b1, 12'h342, 64'h3);
        lane(1, 64'h8000_002c, 1'b0, 5'd0, 64'h0, 1'b1, 12'h343, 64'h4);
        push_commit(2'b00);
        push_csr(12'h342, 64'h3);
        push_csr(12'h343, 64'h4);
        step();
        idle();
        lane(0, 64'h8000_0030, 1'b1, 5'd8, 64'h55, 1'b1, 12'h350, 64'h5);
        lane(1, 64'h8000_0034, 1'b0, 5'd0, 64'h0, 1'b1, 12'h351, 64'h6);
        @(negedge clk);
        chk("full_ready_low", bus.in_ready, 1'b0);
        step();
        @(negedge clk);
        chk("stall_no_commit", bus.commit_valid, 2'b00);
        chk("stall_instret", bus.instret, exp_instret);
        step();
        bus.csr_write_ready = 1'b1;
        step();
        bus.csr_write_ready = 1'b0;
        @(negedge clk);
        chk("count3_ready_low", bus.in_ready, 1'b0);
        chk("head_stable", bus.csr_write_addr, 12'h341);
        step();
        bus.csr_write_ready = 1'b1;
        step();
        bus.csr_write_ready = 1'b0;
        @(negedge clk);
        chk("count2_ready_high", bus.in_ready, 1'b1);
        push_commit(2'b01);
        push_csr(12'h350, 64'h5);
        push_csr(12'h351, 64'h6);
        step();
        idle();
        bus.csr_write_ready = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.csr_pending && waited < 20);
        chk("full_drain_pending", bus.csr_pending, 1'b0);
        chk("full_drain_queue", sq.size(), 0);

        // Bubbles
        step();
        idle();
        lane(0, 64'h8000_0040, 1'b1, 5'd9, 64'h99, 1'b0, 12'h0, 64'h0);
        push_commit(2'b01);
        step();
        idle();
        step();
        @(negedge clk);
        chk("bubble_commit", bus.commit_valid, 2'b00);
        chk("bubble_instret", bus.instret, exp_instret);

        // Reset with three buffered CSR writes
        step();
        bus.csr_write_ready = 1'b0;
        lane(0, 64'h8000_0050, 1'b0, 5'd0, 64'h0, 1'b1, 12'h7c0, 64'h7);
        lane(1, 64'h8000_0054, 1'b0, 5'd0, 64'h0, 1'b1, 12'h7c1, 64'h8);
        push_commit(2'b00);
        step();
        idle();
        lane(0, 64'h8000_0058, 1'b0, 5'd0, 64'h0, 1'b1, 12'h7c2, 64'h9);
        push_commit(2'b00);
        step();
        idle();
        @(negedge clk);
        chk("three_buffered_ready", bus.in_ready, 1'b0);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        exp_instret = 64'd0;
        chk("midrst_csr_valid", bus.csr_write_valid, 1'b0);
        chk("midrst_instret", bus.instret, exp_instret);
        chk("midrst_ready", bus.in_ready, 1'b1);
        chk("midrst_commit", bus.commit_valid, 2'b00);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("commit_queue_empty", cq.size(), 0);
        chk("csr_queue_empty", sq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_commit.md
# writeback_commit

Parametrised multi-lane writeback/commit stage at the tail of the pipeline, after memory. Each cycle it accepts up to LANES retiring instructions with lane 0 oldest. It registers their GPR writes toward the register file and reports committed PCs and an instret count. CSR writes go into an in-order CSR write buffer that drains one entry per cycle to the CSR file under a valid/ready handshake, and the block stalls upstream when that buffer cannot absorb a full bundle.

## Interface
- LANES, 2, number of retire lanes (1..4)
- XLEN, 64, data/PC width
- CSR_DEPTH, 4, CSR write buffer entries; must be ≥ LANES and a power of two
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  LANES  lane i carries a retiring instruction (low = bubble)
- in_ready  out  1  stage accepts the bundle this cycle
- in_pc  in  LANES*XLEN  lane PCs
- in_result  in  LANES*XLEN  GPR write data
- in_dst  in  LANES*5  GPR destination
- in_regwrite  in  LANES  lane writes a GPR
- in_csr_we  in  LANES  lane writes a CSR (any CSRRW/RS/RC/RWI/RSI/RCI)
- in_csr_addr  in  LANES*12  CSR address
- in_csr_data  in  LANES*XLEN  CSR write value
- rf_we  out  LANES  GPR write enable
- rf_waddr  out  LANES*5  GPR write address
- rf_wdata  out  LANES*XLEN  GPR write data
- csr_write_valid  out  1  CSR buffer head valid
- csr_write_addr  out  12  head address
- csr_write_data  out  XLEN  head data
- csr_write_ready  in  1  CSR file consumes head
- csr_pending  out  1  buffer non-empty (decode stalls CSR reads)
- commit_valid  out  LANES  lane committed last cycle
- commit_pc  out  LANES*XLEN  committed PCs
- instret  out  64  retired-instruction counter

## Operation
- Accept = in_ready & in_valid[i] for each lane i. Lanes with in_valid=0 are ignored entirely.
- in_ready = (CSR_DEPTH − count) ≥ LANES, evaluated on the registered count. It does not depend on inputs or on a same-cycle dequeue, so it is conservative.
- GPR path, registered next cycle: rf_we[i] = accept_i & in_regwrite[i] & (in_dst[i] ≠ 0).
- Same-bundle WAW: if a younger lane j>i writes the same nonzero dst, rf_we[i] is forced to 0 and the youngest lane wins.
- When not accepting, rf_we = 0. rf_waddr/rf_wdata follow the input, don't-care when rf_we=0.
- CSR buffer: a circular FIFO with head/tail pointers that wrap mod CSR_DEPTH, plus count (0..CSR_DEPTH).
- Accepted lanes with in_csr_we are enqueued in lane order (lane 0 first), so up to LANES entries per cycle. Multiple writes to the same CSR are kept as separate entries.
- Dequeue happens when csr_write_valid & csr_write_ready.
- Simultaneous enqueue/dequeue: count_next = count + n_enq − deq.
- Head outputs come straight from storage. csr_write_valid = csr_pending = (count ≠ 0).
- commit_valid[i] = registered accept_i; commit_pc is the registered in_pc.
- instret += popcount(accept), wrapping mod 2^64.

## Timing
- Reset (synchronous): count=0 and pointers=0; instret=0; rf_we=0; commit_valid=0; csr_write_valid=0; csr_pending=0; rf_waddr/rf_wdata/commit_pc/csr_write_addr/csr_write_data = 0.
- in_ready=1 in the first cycle after reset.
- GPR writes and commit reports: 1-cycle latency from acceptance.
- CSR write: the earliest csr_write_valid is the cycle after acceptance. Entries drain at most 1 per cycle.
- instret reflects an acceptance the following cycle.
- Full/stall: with count > CSR_DEPTH − LANES, in_ready=0. The bundle must be held by upstream and nothing is committed. A dequeue in that cycle raises in_ready only in the next cycle.
- Empty: csr_write_valid=0, and csr_write_ready is ignored.
- Reset mid-operation drops all buffered CSR writes and clears the counter. Reset wins over any simultaneous accept or dequeue.
- csr_write_ready may toggle freely. Head entry and outputs stay stable while valid & !ready.

## Test plan
- Reset, then bundle {lane0: pc=0x80000000, dst=5, res=0x11; lane1: pc=0x80000004, dst=6, res=0x22} → next cycle rf_we=2'b11, commit_valid=2'b11, instret=2.
- Same-bundle WAW: both lanes dst=7, lane0 res=1, lane1 res=2 → only lane1 writes x7=2. dst=0 with regwrite → rf_we=0 while instret still increments.
- Two CSR writes in one bundle (0x300←0xA, 0x305←0xB), csr_write_ready=1 → 0x300/0xA and 0x305/0xB on consecutive cycles in order, then csr_pending=0.
- Hold csr_write_ready=0 with CSR_DEPTH=4, LANES=2, feeding two-CSR bundles → after 2 bundles (count=4) in_ready=0. Raising ready for one cycle → count=3, in_ready still 0. A second dequeue → in_ready=1.
- Bubbles: in_valid=2'b01 then 2'b00 → commit_valid 2'b01 then 2'b00, instret +1 total.
- Assert reset with 3 buffered CSR writes → next cycle csr_write_valid=0, instret=0, in_ready=1.
